// File: rtl/noc_output_vc_arbiter.sv
// Output-port switch/VC arbiter: round-robin over input ports, wormhole lock per packet, per-VC credit tracking.
// Optional build macro NOC_RESP_PRIORITY_EN: eligible response packets win over requests in IDLE.
module noc_output_vc_arbiter #(
  parameter int NUM_IN       = 5,
  parameter int VC_COUNT     = 3,
  parameter int BUFFER_DEPTH = 4,
  parameter int VC_W         = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1,
  parameter int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         req_valid,
  input  logic [NUM_IN*VC_W-1:0]    req_vc,
  input  logic [NUM_IN-1:0]         req_head,
  input  logic [NUM_IN-1:0]         req_tail,
  input  logic [NUM_IN-1:0]         req_is_resp,
  input  logic                      credit_ret,
  input  logic [VC_W-1:0]           credit_ret_vc,
  output logic [NUM_IN-1:0]         grant,
  output logic                      out_valid,
  output logic [VC_W-1:0]           out_vc,
  output logic                      locked,
  output logic [VC_COUNT*CNT_W-1:0] credit_cnt,
  output logic                      credit_err
);

  localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int VC_PAD = 1 << VC_W;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  lock_in_q, lock_in_d;
  logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
  logic              credit_err_q, credit_err_d;

  logic [VC_PAD-1:0]   credit_ok;
  logic [VC_COUNT-1:0] overflow;
  logic [NUM_IN-1:0]   head_elig;
  logic [NUM_IN-1:0]   cand;
  logic [NUM_IN-1:0]   grant_c;
  logic [VC_W-1:0]     vc_c;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  int                  probe;

  // VC codes beyond VC_COUNT map to a permanently empty credit slot, so they never win.
  for (genvar gi = 0; gi < VC_PAD; gi++) begin : g_vc
    if (gi < VC_COUNT) begin : g_real
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             take, give;

      assign take          = (|grant_c) && (int'(vc_c) == gi);
      assign give          = credit_ret && (int'(credit_ret_vc) == gi);
      assign overflow[gi]  = give && !take && (cnt_q == CNT_W'(BUFFER_DEPTH));
      assign credit_ok[gi] = (cnt_q != '0);
      assign credit_cnt[gi*CNT_W +: CNT_W] = cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (take && !give) begin
          cnt_d = cnt_q - 1'b1;
        end else if (give && !take && !overflow[gi]) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= CNT_W'(BUFFER_DEPTH);
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_pad
      assign credit_ok[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    logic [VC_W-1:0] vc_i;
    assign vc_i          = req_vc[gi*VC_W +: VC_W];
    assign head_elig[gi] = req_valid[gi] & req_head[gi] & credit_ok[vc_i];
  end

`ifdef NOC_RESP_PRIORITY_EN
  always_comb begin
    cand = head_elig;
    if (|(head_elig & req_is_resp)) begin
      cand = head_elig & req_is_resp;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^req_is_resp;
  assign cand        = head_elig;
`endif

  // Search starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      probe = (int'(rr_ptr_q) + k) % NUM_IN;
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(probe);
      end
    end
  end

  always_comb begin
    grant_c = '0;
    vc_c    = lock_vc_q;
    if (state_q == LOCKED) begin
      if (req_valid[lock_in_q] && credit_ok[lock_vc_q]) begin
        grant_c[lock_in_q] = 1'b1;
      end
    end else begin
      vc_c = '0;
      if (win_found) begin
        grant_c[win_idx] = 1'b1;
        vc_c             = req_vc[int'(win_idx)*VC_W +: VC_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_in_d = lock_in_q;
    lock_vc_d = lock_vc_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        rr_ptr_d = win_idx;
        if (!req_tail[win_idx]) begin
          state_d   = LOCKED;
          lock_in_d = win_idx;
          lock_vc_d = vc_c;
        end
      end
    end else if ((|grant_c) && req_tail[lock_in_q]) begin
      state_d = IDLE;
    end
  end

  assign credit_err_d = credit_err_q | (|overflow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NUM_IN - 1);
      lock_in_q    <= '0;
      lock_vc_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_in_q    <= lock_in_d;
      lock_vc_q    <= lock_vc_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign grant      = rst_n ? grant_c : '0;
  assign out_valid  = |grant;
  assign out_vc     = rst_n ? vc_c : '0;
  assign locked     = (state_q == LOCKED);
  assign credit_err = credit_err_q;

  // A head on the owning input mid-packet is still forwarded as a body flit.
  a_no_head_while_locked: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == LOCKED && req_valid[lock_in_q] && req_head[lock_in_q]));

endmodule

// File: tb/tb_noc_output_vc_arbiter.sv
// Directed and randomized checks of noc_output_vc_arbiter against a packet-level reference model.
module tb_noc_output_vc_arbiter;
  localparam int NUM_IN = 5;
  localparam int NVC    = 3;
  localparam int DEPTH  = 4;
`ifdef NOC_RESP_PRIORITY_EN
  localparam bit RESP_PRIO = 1'b1;
`else
  localparam bit RESP_PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] req_valid = '0, req_head = '0, req_tail = '0, req_is_resp = '0;
  logic [9:0] req_vc = '0;
  logic       credit_ret = 1'b0;
  logic [1:0] credit_ret_vc = '0;
  logic [4:0] grant;
  logic       out_valid, locked, credit_err;
  logic [1:0] out_vc;
  logic [8:0] credit_cnt;

  noc_output_vc_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vc(req_vc), .req_head(req_head),
    .req_tail(req_tail), .req_is_resp(req_is_resp), .credit_ret(credit_ret),
    .credit_ret_vc(credit_ret_vc), .grant(grant), .out_valid(out_valid), .out_vc(out_vc),
    .locked(locked), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit m_locked;
  int m_lock_in, m_lock_vc, m_rr;
  int m_cred[NVC];
  bit m_err;

  logic [4:0] obs_grant;
  logic       obs_locked, obs_err;
  logic [8:0] obs_cc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_lock_in = 0;
    m_lock_vc = 0;
    m_rr      = NUM_IN - 1;
    m_err     = 1'b0;
    for (int v = 0; v < NVC; v++) m_cred[v] = DEPTH;
  endtask

  function automatic bit elig(input int i);
    int vc_i;
    vc_i = int'(req_vc[i*2 +: 2]);
    if (vc_i >= NVC) return 1'b0;
    return req_valid[i] && req_head[i] && (m_cred[vc_i] > 0);
  endfunction

  task automatic model_pick(output int g, output int gvc);
    bit any_resp;
    int i;
    g = -1;
    gvc = 0;
    any_resp = 1'b0;
    if (m_locked) begin
      if (req_valid[m_lock_in] && m_cred[m_lock_vc] > 0) begin
        g = m_lock_in;
        gvc = m_lock_vc;
      end
    end else begin
      if (RESP_PRIO) begin
        for (int j = 0; j < NUM_IN; j++) if (elig(j) && req_is_resp[j]) any_resp = 1'b1;
      end
      for (int k = 1; k <= NUM_IN; k++) begin
        i = (m_rr + k) % NUM_IN;
        if (g < 0 && elig(i) && (!any_resp || req_is_resp[i])) begin
          g = i;
          gvc = int'(req_vc[i*2 +: 2]);
        end
      end
    end
  endtask

  task automatic model_update(input int g, input int gvc);
    int rv;
    if (g >= 0) begin
      if (!m_locked) begin
        m_rr = g;
        if (!req_tail[g]) begin
          m_locked = 1'b1;
          m_lock_in = g;
          m_lock_vc = gvc;
        end
      end else if (req_tail[g]) begin
        m_locked = 1'b0;
      end
      m_cred[gvc]--;
    end
    if (credit_ret) begin
      rv = int'(credit_ret_vc);
      if (g >= 0 && rv == gvc) m_cred[rv]++;
      else if (m_cred[rv] == DEPTH) m_err = 1'b1;
      else m_cred[rv]++;
    end
  endtask

  task automatic step(input logic [4:0] v, input logic [9:0] vc, input logic [4:0] h,
                      input logic [4:0] t, input logic [4:0] rs, input logic cr, input logic [1:0] crv);
    int g, gvc;
    logic [4:0] eg;
    logic [8:0] ecc;
    @(negedge clk);
    req_valid = v; req_vc = vc; req_head = h; req_tail = t; req_is_resp = rs;
    credit_ret = cr; credit_ret_vc = crv;
    #1;
    model_pick(g, gvc);
    eg = (g >= 0) ? 5'(1 << g) : 5'd0;
    for (int k = 0; k < NVC; k++) ecc[k*3 +: 3] = 3'(m_cred[k]);
    check_val("grant", 32'(grant), 32'(eg));
    check_val("out_valid", 32'(out_valid), 32'(g >= 0));
    if (g >= 0 || m_locked) check_val("out_vc", 32'(out_vc), m_locked ? m_lock_vc : gvc);
    check_val("locked", 32'(locked), 32'(m_locked));
    check_val("credit_cnt", 32'(credit_cnt), 32'(ecc));
    check_val("credit_err", 32'(credit_err), 32'(m_err));
    obs_grant = grant; obs_locked = locked; obs_cc = credit_cnt; obs_err = credit_err;
    $display("cyc %0d req=%b head=%b tail=%b ret=%0d/%0d grant=%b vc=%0d locked=%0d cred=%h err=%0d",
             cyc, v, h, t, cr, crv, grant, out_vc, locked, credit_cnt, credit_err);
    model_update(g, gvc);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1; req_head = '1; req_tail = '1; req_vc = '0; req_is_resp = '0;
    credit_ret = 1'b0; credit_ret_vc = '0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_grant", 32'(grant), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_vc", 32'(out_vc), 0);
    check_val("rst_locked", 32'(locked), 0);
    check_val("rst_credit", 32'(credit_cnt), 32'h124);
    check_val("rst_err", 32'(credit_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0; req_head = '0; req_tail = '0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] v, h, t, rs;
    logic [9:0] vc;
    model_reset();

    // Single-flit heads on inputs 0 and 2, VC0.
    do_reset();
    step(5'b00101, 10'h000, 5'b00101, 5'b00101, 5'b0, 1'b0, 2'd0);
    check_val("s1_g0", 32'(obs_grant), 32'h01);
    step(5'b00101, 10'h000, 5'b00101, 5'b00101, 5'b0, 1'b0, 2'd0);
    check_val("s1_g1", 32'(obs_grant), 32'h04);
    step(5'b00101, 10'h000, 5'b00101, 5'b00101, 5'b0, 1'b0, 2'd0);
    check_val("s1_g2", 32'(obs_grant), 32'h01);
    step(5'b0, 10'h000, 5'b0, 5'b0, 5'b0, 1'b0, 2'd0);
    check_val("s1_cred", 32'(obs_cc[2:0]), 1);

    // 3-flit packet on input 1 VC2 while input 3 keeps requesting.
    do_reset();
    step(5'b01010, 10'h008, 5'b01010, 5'b01000, 5'b0, 1'b0, 2'd0);
    check_val("s2_g0", 32'(obs_grant), 32'h02);
    step(5'b01010, 10'h008, 5'b01000, 5'b01000, 5'b0, 1'b0, 2'd0);
    check_val("s2_g1", 32'(obs_grant), 32'h02);
    check_val("s2_lk1", 32'(obs_locked), 1);
    step(5'b01010, 10'h008, 5'b01000, 5'b01010, 5'b0, 1'b0, 2'd0);
    check_val("s2_g2", 32'(obs_grant), 32'h02);
    check_val("s2_lk2", 32'(obs_locked), 1);
    step(5'b01000, 10'h000, 5'b01000, 5'b01000, 5'b0, 1'b0, 2'd0);
    check_val("s2_g3", 32'(obs_grant), 32'h08);
    check_val("s2_lk3", 32'(obs_locked), 0);

    // Exhaust VC1, then a returned credit is usable one cycle later.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      step(5'b00001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
      check_val("s3_g", 32'(obs_grant), 32'h01);
    end
    step(5'b00001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
    check_val("s3_stall", 32'(obs_grant), 0);
    check_val("s3_cred0", 32'(obs_cc[5:3]), 0);
    step(5'b00001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b1, 2'd1);
    check_val("s3_same", 32'(obs_grant), 0);
    step(5'b00001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
    check_val("s3_after", 32'(obs_grant), 32'h01);

    // Grant and return on the same VC; then an overflowing return.
    do_reset();
    repeat (2) step(5'b00001, 10'h000, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
    step(5'b00001, 10'h000, 5'b00001, 5'b00001, 5'b0, 1'b1, 2'd0);
    step(5'b0, 10'h000, 5'b0, 5'b0, 5'b0, 1'b0, 2'd0);
    check_val("s4_cnt", 32'(obs_cc[2:0]), 2);
    step(5'b0, 10'h000, 5'b0, 5'b0, 5'b0, 1'b1, 2'd2);
    step(5'b0, 10'h000, 5'b0, 5'b0, 5'b0, 1'b0, 2'd0);
    check_val("s4_err", 32'(obs_err), 1);
    check_val("s4_vc2", 32'(obs_cc[8:6]), 4);

    // Wormhole stall: input 4 owns VC0 with no credit; input 0 must wait.
    do_reset();
    step(5'b10000, 10'h000, 5'b10000, 5'b0, 5'b0, 1'b0, 2'd0);
    check_val("s5_head", 32'(obs_grant), 32'h10);
    repeat (3) step(5'b10000, 10'h000, 5'b0, 5'b0, 5'b0, 1'b0, 2'd0);
    for (int n = 0; n < 3; n++) begin
      step(5'b10001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
      check_val("s5_stall", 32'(obs_grant), 0);
      check_val("s5_lock", 32'(obs_locked), 1);
    end
    step(5'b10001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b1, 2'd0);
    check_val("s5_ret", 32'(obs_grant), 0);
    step(5'b10001, 10'h001, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
    check_val("s5_resume", 32'(obs_grant), 32'h10);

    // Response class versus request class with rr_ptr at 0.
    do_reset();
    step(5'b00001, 10'h000, 5'b00001, 5'b00001, 5'b0, 1'b0, 2'd0);
    step(5'b01010, 10'h040, 5'b01010, 5'b01010, 5'b01000, 1'b0, 2'd0);
    check_val("s6_class", 32'(obs_grant), RESP_PRIO ? 32'h08 : 32'h02);

    // Random traffic, with one reset in the middle of whatever is in flight.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      v = 5'($urandom); h = 5'($urandom); t = 5'($urandom); rs = 5'($urandom);
      for (int j = 0; j < NUM_IN; j++) vc[j*2 +: 2] = 2'($urandom_range(0, 2));
      if (m_locked) h[m_lock_in] = 1'b0;
      step(v, vc, h, t, rs, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
